// File: rtl/word_packer_pkg.sv
// Shared types and sizing for the word packer and its matcher.
// LEN_W is derived from the window depth so both sides agree on consume_len.
package word_packer_pkg;

  localparam int DEF_WORD_LENGTH = 3;
  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_POS_WIDTH   = 16;

  function automatic int len_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int LEN_W = len_w(DEF_WORD_LENGTH);

  typedef logic [DEF_DATA_WIDTH-1:0] byte_t;

  typedef enum logic [1:0] {
    S_FILL,
    S_FULL,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/word_packer_if.sv
// Byte stream in, sliding window out, consume feedback from the matcher.
// master = stream source / matcher side, slave = packer.
interface word_packer_if
  import word_packer_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int POS_WIDTH   = DEF_POS_WIDTH,
  parameter int LW          = len_w(WORD_LENGTH)
);

  logic [DATA_WIDTH-1:0]             in_data;
  logic                              in_valid;
  logic                              in_last;
  logic                              in_ready;
  logic [WORD_LENGTH*DATA_WIDTH-1:0] word;
  logic [LW-1:0]                     word_len;
  logic                              word_valid;
  logic [POS_WIDTH-1:0]              word_pos;
  logic                              consume_valid;
  logic [LW-1:0]                     consume_len;
  logic                              done;
  logic                              err;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    output consume_valid,
    output consume_len,
    input  in_ready,
    input  word,
    input  word_len,
    input  word_valid,
    input  word_pos,
    input  done,
    input  err
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    input  consume_valid,
    input  consume_len,
    output in_ready,
    output word,
    output word_len,
    output word_valid,
    output word_pos,
    output done,
    output err
  );

endinterface

// File: rtl/word_packer.sv
// Packs a byte stream into a WORD_LENGTH-slot window, slot 0 in the MSB.
// Shifts out consumed bytes, refills, and drains the tail after in_last.
module word_packer
  import word_packer_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int POS_WIDTH   = DEF_POS_WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  word_packer_if.slave p
);

  localparam int LW = len_w(WORD_LENGTH);

  typedef logic [DATA_WIDTH-1:0] slot_t;

  state_e               state_q, state_d;
  slot_t                win_q [WORD_LENGTH];
  slot_t                win_d [WORD_LENGTH];
  logic [LW-1:0]        cnt_q, cnt_d;
  logic [POS_WIDTH-1:0] pos_q, pos_d;
  logic                 in_ready_q, in_ready_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic                 accept;
  logic                 legal;
  logic [WORD_LENGTH-1:0][DATA_WIDTH-1:0] word_w;

  always_comb begin
    accept = p.in_valid && in_ready_q;
    legal  = p.consume_valid && valid_q &&
             (p.consume_len != '0) &&
             (p.consume_len <= cnt_q);
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    err_d   = err_q | (p.consume_valid && !legal);

    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          for (int i = 0; i < WORD_LENGTH; i++) begin
            if (cnt_q == LW'(i)) win_d[i] = p.in_data;
          end
          cnt_d = cnt_q + LW'(1);
          if (p.in_last) begin
            state_d = S_DRAIN;
          end else if (cnt_d == LW'(WORD_LENGTH)) begin
            state_d = S_FULL;
          end
        end
      end
      S_FULL, S_DRAIN: begin
        if (legal) begin
          // slot i takes slot i+n; anything shifted in from past the end is zero
          for (int i = 0; i < WORD_LENGTH; i++) begin
            win_d[i] = '0;
            for (int j = 0; j < WORD_LENGTH; j++) begin
              if (j == i + int'(p.consume_len)) win_d[i] = win_q[j];
            end
          end
          cnt_d = cnt_q - p.consume_len;
          pos_d = pos_q + POS_WIDTH'(p.consume_len);
          if (state_q == S_FULL) begin
            state_d = S_FILL;
          end else if (cnt_d == '0) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        pos_d   = '0;
        state_d = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase

    in_ready_d = (state_d == S_FILL);
    valid_d    = (state_d == S_FULL) ||
                 ((state_d == S_DRAIN) && (cnt_d != '0));
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FILL;
      win_q      <= '{default: '0};
      cnt_q      <= '0;
      pos_q      <= '0;
      in_ready_q <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      cnt_q      <= cnt_d;
      pos_q      <= pos_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < WORD_LENGTH; i++) begin
      word_w[WORD_LENGTH-1-i] = win_q[i];
    end
  end

  assign p.in_ready   = in_ready_q;
  assign p.word       = word_w;
  assign p.word_len   = cnt_q;
  assign p.word_valid = valid_q;
  assign p.word_pos   = pos_q;
  assign p.done       = done_q;
  assign p.err        = err_q;

  // accept and consume are kept apart by never exposing both handshakes
  a_ready_valid_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(in_ready_q && valid_q)
  );

  a_cnt_range: assert property (
    @(posedge clk) disable iff (!rst_n)
    cnt_q <= LW'(WORD_LENGTH)
  );

endmodule

// File: tb/tb_word_packer.sv
// Directed bench for word_packer: fill, consume, drain, errors, reset.
// Each task drives one scenario and checks against hand-computed values.
module tb_word_packer;
  import word_packer_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  word_packer_if dut_if ();

  word_packer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p     (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input byte_t b, input logic last);
    dut_if.in_data  = b;
    dut_if.in_valid = 1'b1;
    dut_if.in_last  = last;
    tick();
    dut_if.in_valid = 1'b0;
    dut_if.in_last  = 1'b0;
    dut_if.in_data  = '0;
  endtask

  task automatic consume(input logic [LEN_W-1:0] n);
    dut_if.consume_valid = 1'b1;
    dut_if.consume_len   = n;
    tick();
    dut_if.consume_valid = 1'b0;
    dut_if.consume_len   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dut_if.in_data = '0;
    dut_if.in_valid = 1'b0;
    dut_if.in_last = 1'b0;
    dut_if.consume_valid = 1'b0;
    dut_if.consume_len = '0;
    tick();
    tick();
    total++;
    if (dut_if.word !== 24'h0) begin
      bad++; $display("FAIL rst_word got=%h exp=%h", dut_if.word, 24'h0);
    end
    total++;
    if ({dut_if.in_ready, dut_if.word_valid, dut_if.done, dut_if.err} !== 4'b0) begin
      bad++; $display("FAIL rst_flags got=%b exp=%b",
        {dut_if.in_ready, dut_if.word_valid, dut_if.done, dut_if.err}, 4'b0);
    end
    total++;
    if ({dut_if.word_len, dut_if.word_pos} !== 18'h0) begin
      bad++; $display("FAIL rst_len_pos got=%h exp=%h",
        {dut_if.word_len, dut_if.word_pos}, 18'h0);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (dut_if.in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b exp=%b", dut_if.in_ready, 1'b1);
    end
  endtask

  task automatic test_fill();
    send(8'h48, 1'b0);
    send(8'h65, 1'b0);
    send(8'h6C, 1'b0);
    total++;
    if (dut_if.word !== 24'h48656C) begin
      bad++; $display("FAIL fill_word got=%h exp=%h", dut_if.word, 24'h48656C);
    end
    total++;
    if (dut_if.word_len !== 2'd3) begin
      bad++; $display("FAIL fill_len got=%0d exp=%0d", dut_if.word_len, 3);
    end
    total++;
    if ({dut_if.word_valid, dut_if.in_ready} !== 2'b10) begin
      bad++; $display("FAIL fill_hs got=%b exp=%b",
        {dut_if.word_valid, dut_if.in_ready}, 2'b10);
    end
    total++;
    if (dut_if.word_pos !== 16'd0) begin
      bad++; $display("FAIL fill_pos got=%0d exp=%0d", dut_if.word_pos, 0);
    end
  endtask

  task automatic test_partial_refill();
    consume(2'd2);
    total++;
    if (dut_if.word !== 24'h6C0000) begin
      bad++; $display("FAIL part_word got=%h exp=%h", dut_if.word, 24'h6C0000);
    end
    total++;
    if ({dut_if.word_len, dut_if.word_pos} !== {2'd1, 16'd2}) begin
      bad++; $display("FAIL part_len_pos got=%h exp=%h",
        {dut_if.word_len, dut_if.word_pos}, {2'd1, 16'd2});
    end
    total++;
    if ({dut_if.in_ready, dut_if.word_valid} !== 2'b10) begin
      bad++; $display("FAIL part_hs got=%b exp=%b",
        {dut_if.in_ready, dut_if.word_valid}, 2'b10);
    end
    send(8'h6C, 1'b0);
    total++;
    if (dut_if.word !== 24'h6C6C00) begin
      bad++; $display("FAIL refill1_word got=%h exp=%h", dut_if.word, 24'h6C6C00);
    end
    send(8'h6F, 1'b1);
    total++;
    if (dut_if.word !== 24'h6C6C6F) begin
      bad++; $display("FAIL refill_word got=%h exp=%h", dut_if.word, 24'h6C6C6F);
    end
    total++;
    if ({dut_if.word_valid, dut_if.in_ready, dut_if.word_len} !== {2'b10, 2'd3}) begin
      bad++; $display("FAIL refill_hs got=%b exp=%b",
        {dut_if.word_valid, dut_if.in_ready, dut_if.word_len}, {2'b10, 2'd3});
    end
  endtask

  task automatic test_drain_done();
    consume(2'd1);
    total++;
    if ({dut_if.word, dut_if.word_len} !== {24'h6C6F00, 2'd2}) begin
      bad++; $display("FAIL drain1 got=%h exp=%h",
        {dut_if.word, dut_if.word_len}, {24'h6C6F00, 2'd2});
    end
    total++;
    if (dut_if.word_pos !== 16'd3) begin
      bad++; $display("FAIL drain1_pos got=%0d exp=%0d", dut_if.word_pos, 3);
    end
    consume(2'd2);
    total++;
    if ({dut_if.done, dut_if.word_valid, dut_if.word_len} !== {2'b10, 2'd0}) begin
      bad++; $display("FAIL drain_done got=%b exp=%b",
        {dut_if.done, dut_if.word_valid, dut_if.word_len}, {2'b10, 2'd0});
    end
    total++;
    if (dut_if.word !== 24'h0) begin
      bad++; $display("FAIL drain_word got=%h exp=%h", dut_if.word, 24'h0);
    end
    tick();
    total++;
    if ({dut_if.done, dut_if.in_ready, dut_if.word_pos} !== {2'b01, 16'd0}) begin
      bad++; $display("FAIL after_done got=%h exp=%h",
        {dut_if.done, dut_if.in_ready, dut_if.word_pos}, {2'b01, 16'd0});
    end
  endtask

  task automatic test_short_stream();
    send(8'h41, 1'b1);
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.word_valid} !== {24'h410000, 2'd1, 1'b1}) begin
      bad++; $display("FAIL short_word got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.word_valid}, {24'h410000, 2'd1, 1'b1});
    end
    consume(2'd1);
    total++;
    if (dut_if.done !== 1'b1) begin
      bad++; $display("FAIL short_done got=%b exp=%b", dut_if.done, 1'b1);
    end
    tick();
    total++;
    if ({dut_if.done, dut_if.in_ready, dut_if.word_pos} !== {2'b01, 16'd0}) begin
      bad++; $display("FAIL short_after got=%h exp=%h",
        {dut_if.done, dut_if.in_ready, dut_if.word_pos}, {2'b01, 16'd0});
    end
    total++;
    if (dut_if.err !== 1'b0) begin
      bad++; $display("FAIL short_err got=%b exp=%b", dut_if.err, 1'b0);
    end
  endtask

  task automatic test_protocol_errors();
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    consume(2'd0);
    total++;
    if ({dut_if.err, dut_if.word, dut_if.word_len} !== {1'b1, 24'h010203, 2'd3}) begin
      bad++; $display("FAIL err_zero got=%h exp=%h",
        {dut_if.err, dut_if.word, dut_if.word_len}, {1'b1, 24'h010203, 2'd3});
    end
    total++;
    if ({dut_if.word_valid, dut_if.in_ready, dut_if.word_pos} !== {2'b10, 16'd0}) begin
      bad++; $display("FAIL err_zero_state got=%h exp=%h",
        {dut_if.word_valid, dut_if.in_ready, dut_if.word_pos}, {2'b10, 16'd0});
    end
    consume(2'd2);
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.word_pos} !== {24'h030000, 2'd1, 16'd2}) begin
      bad++; $display("FAIL err_legal got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.word_pos}, {24'h030000, 2'd1, 16'd2});
    end
    consume(2'd1);
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.in_ready, dut_if.word_pos}
        !== {24'h030000, 2'd1, 1'b1, 16'd2}) begin
      bad++; $display("FAIL err_fill_consume got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.in_ready, dut_if.word_pos},
        {24'h030000, 2'd1, 1'b1, 16'd2});
    end
    send(8'h04, 1'b1);
    consume(2'd1);
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.word_pos} !== {24'h040000, 2'd1, 16'd3}) begin
      bad++; $display("FAIL err_drain1 got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.word_pos}, {24'h040000, 2'd1, 16'd3});
    end
    consume(2'd3);
    total++;
    if ({dut_if.err, dut_if.word, dut_if.word_len, dut_if.word_valid, dut_if.done}
        !== {1'b1, 24'h040000, 2'd1, 2'b10}) begin
      bad++; $display("FAIL err_big got=%h exp=%h",
        {dut_if.err, dut_if.word, dut_if.word_len, dut_if.word_valid, dut_if.done},
        {1'b1, 24'h040000, 2'd1, 2'b10});
    end
    consume(2'd1);
    total++;
    if ({dut_if.done, dut_if.err} !== 2'b11) begin
      bad++; $display("FAIL err_done got=%b exp=%b", {dut_if.done, dut_if.err}, 2'b11);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.word_valid} !== {24'h0A0B00, 2'd2, 1'b1}) begin
      bad++; $display("FAIL mid_pre got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.word_valid}, {24'h0A0B00, 2'd2, 1'b1});
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.word_pos} !== 42'h0) begin
      bad++; $display("FAIL mid_rst_data got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.word_pos}, 42'h0);
    end
    total++;
    if ({dut_if.in_ready, dut_if.word_valid, dut_if.done, dut_if.err} !== 4'b0) begin
      bad++; $display("FAIL mid_rst_flags got=%b exp=%b",
        {dut_if.in_ready, dut_if.word_valid, dut_if.done, dut_if.err}, 4'b0);
    end
    #1;
    rst_n = 1'b1;
    tick();
    total++;
    if (dut_if.in_ready !== 1'b1) begin
      bad++; $display("FAIL mid_ready got=%b exp=%b", dut_if.in_ready, 1'b1);
    end
    send(8'h0C, 1'b0);
    send(8'h0D, 1'b0);
    send(8'h0E, 1'b0);
    total++;
    if ({dut_if.word, dut_if.word_len, dut_if.word_pos} !== {24'h0C0D0E, 2'd3, 16'd0}) begin
      bad++; $display("FAIL mid_repack got=%h exp=%h",
        {dut_if.word, dut_if.word_len, dut_if.word_pos}, {24'h0C0D0E, 2'd3, 16'd0});
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fill();
    test_partial_refill();
    test_drain_done();
    test_short_stream();
    test_protocol_errors();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
